// File: rtl/barrier_scroll_ctrl.sv
// Barrier consumer: fetches a descriptor, scrolls it left per frame, retires it, and reports
// per-pixel draw, sticky collision and score. Optional macro BARRIER_ACCEL_EN ramps the speed.
module barrier_scroll_ctrl #(
  parameter int SPEED       = 2,
  parameter int SCORE_W     = 16,
  parameter int ACCEL_EVERY = 8,
  parameter int MAX_SPEED   = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Frame_Tick,
  input  logic               Run,
  output logic               Param_Req,
  input  logic               Param_Valid,
  input  logic [9:0]         BarrierX_In,
  input  logic [9:0]         BarrierY_In,
  input  logic [9:0]         Height_In,
  input  logic [9:0]         Length_In,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic [9:0]         PlayerX,
  input  logic [9:0]         PlayerY,
  input  logic [9:0]         PlayerSize,
  output logic               Barrier_On,
  output logic               Barrier_Active,
  output logic [9:0]         Barrier_X,
  output logic [9:0]         Barrier_Y,
  output logic               Collision,
  output logic [SCORE_W-1:0] Score
);

  if (SPEED < 1 || SPEED > 15 || MAX_SPEED < SPEED || MAX_SPEED > 15 ||
      ACCEL_EVERY < 1 || SCORE_W < 1) begin : g_param_check
    $error("barrier_scroll_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, REQUEST, ACTIVE, RETIRE} state_t;

  state_t             state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d, h_q, h_d, l_q, l_d;
  logic               on_q, on_d, coll_q, coll_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         speed;

`ifdef BARRIER_ACCEL_EN
  localparam int CNT_W = (ACCEL_EVERY > 1) ? $clog2(ACCEL_EVERY) : 1;

  logic [3:0]       speed_q, speed_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

  always_comb begin
    speed_d   = speed_q;
    acc_cnt_d = acc_cnt_q;
    if (state_q == RETIRE && Run) begin
      if (acc_cnt_q == CNT_W'(ACCEL_EVERY - 1)) begin
        acc_cnt_d = '0;
        if (speed_q < 4'(MAX_SPEED)) speed_d = speed_q + 4'd1;
      end else begin
        acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      speed_q   <= 4'(SPEED);
      acc_cnt_q <= '0;
    end else begin
      speed_q   <= speed_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign speed = speed_q;
`else
  assign speed = 4'(SPEED);
`endif

  // Geometry is evaluated one bit wider so right/bottom edges never wrap past 1023.
  logic [10:0] x_end, y_end, px_lo, px_hi, py_lo, py_hi;
  logic        overlap, in_rect;

  assign x_end   = {1'b0, x_q} + {1'b0, l_q};
  assign y_end   = {1'b0, y_q} + {1'b0, h_q};
  assign px_lo   = (PlayerX >= PlayerSize) ? {1'b0, PlayerX - PlayerSize} : 11'd0;
  assign py_lo   = (PlayerY >= PlayerSize) ? {1'b0, PlayerY - PlayerSize} : 11'd0;
  assign px_hi   = {1'b0, PlayerX} + {1'b0, PlayerSize};
  assign py_hi   = {1'b0, PlayerY} + {1'b0, PlayerSize};
  assign overlap = (px_lo < x_end) && (px_hi >= {1'b0, x_q}) &&
                   (py_lo < y_end) && (py_hi >= {1'b0, y_q});
  assign in_rect = (DrawX >= x_q) && ({1'b0, DrawX} < x_end) &&
                   (DrawY >= y_q) && ({1'b0, DrawY} < y_end);

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    h_d     = h_q;
    l_d     = l_q;
    score_d = score_q;
    on_d    = (state_q == ACTIVE) && in_rect;
    coll_d  = coll_q || ((state_q == ACTIVE) && overlap);
    if (!Run) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = REQUEST;
        REQUEST: begin
          if (Param_Valid) begin
            x_d     = BarrierX_In;
            y_d     = BarrierY_In;
            h_d     = (Height_In == 10'd0) ? 10'd1 : Height_In;
            l_d     = (Length_In == 10'd0) ? 10'd1 : Length_In;
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          // A collided barrier freezes in place so the crash stays visible.
          if (Frame_Tick && !coll_q) begin
            if (x_q < {6'd0, speed}) state_d = RETIRE;
            else                     x_d     = x_q - {6'd0, speed};
          end
        end
        RETIRE: begin
          state_d = REQUEST;
          if (!coll_q) score_d = score_q + SCORE_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      h_q     <= '0;
      l_q     <= '0;
      on_q    <= 1'b0;
      coll_q  <= 1'b0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      h_q     <= h_d;
      l_q     <= l_d;
      on_q    <= on_d;
      coll_q  <= coll_d;
      score_q <= score_d;
    end
  end

  assign Param_Req      = (state_q == REQUEST);
  assign Barrier_Active = (state_q == ACTIVE);
  assign Barrier_X      = x_q;
  assign Barrier_Y      = y_q;
  assign Barrier_On     = on_q;
  assign Collision      = coll_q;
  assign Score          = score_q;

endmodule
